mod_instruction_fetch: RTL
==========================

MOD_INSTRUCTION_FETCH -- requirements
Module: mod_instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, word address of the first fetch after start.
REQ-004 SHALL have ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin fetching from RESET_PC.
- imem_addr  output  ADDR_W  word address to the instruction ROM, which reads combinationally.
- imem_instr  input  DATA_W  ROM data for imem_addr, valid in the same cycle.
- imem_end  input  1  ROM flag: imem_addr is past the program end.
- redirect_valid  input  1  branch/jump taken.
- redirect_addr  input  ADDR_W  redirect target, word address.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  downstream accepts the instruction this cycle.
- out_instr  output  DATA_W  fetched instruction.
- out_pc  output  ADDR_W  word address of out_instr.
- halted  output  1  high in state HALT.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, HALT; state after reset is IDLE.
REQ-006 IDLE: start=1 -> RUN with pc<=RESET_PC; otherwise stay in IDLE; redirect_valid is ignored.
REQ-007 imem_addr SHALL equal the pc register combinationally in all states.
REQ-008 Output slot is one register set (out_valid, out_instr, out_pc); the slot is free when out_valid=0 or out_ready=1.
REQ-009 RUN, slot free, imem_end=0, no redirect: capture out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
REQ-010 RUN, slot not free: hold pc and all outputs unchanged; no instruction is skipped or duplicated.
REQ-011 RUN, slot free, imem_end=1: capture nothing; out_valid<=0 if out_ready=1, otherwise hold; next state is HALT.
REQ-012 HALT: pc frozen; a pending slot drains normally; halted=1.
REQ-013 redirect_valid=1 in RUN or HALT has priority over every other event: out_valid<=0 (in-flight beat dropped even if out_ready=1), pc<=redirect_addr, next state is RUN.
REQ-014 Fetch latency: start sampled at edge N gives out_valid=1 from cycle N+2; redirect has the same 2-cycle latency.
REQ-015 Throughput SHALL be one instruction per cycle while out_ready=1 and imem_end=0.
REQ-016 pc+1 SHALL wrap modulo 2^ADDR_W (all-ones -> 0) with no error flag.
REQ-017 out_instr and out_pc SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-018 rst_n=0 at an edge: state<=IDLE, pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, halted=0; reset overrides start and redirect.
REQ-019 Reset mid-RUN SHALL discard the pending slot; no beat is presented after reset until start.

Structure
REQ-020 FSM state encoding, ADDR_W/DATA_W defaults and RESET_PC SHALL live in the shared MIPS package.
REQ-021 The output slot SHALL be a sub-module mod_fetch_slot (one-entry valid/ready register with flush); the FSM and pc stay in the top.

Verification
REQ-022 Bench SHALL use a model ROM holding 13 words: addr1=0x20010001, addr2=0x00011020, addr12=0x0800000C, imem_end=1 for addr>12.
REQ-023 Start, out_ready=1: 13 beats, out_pc 0..12 in consecutive cycles, addr1 beat = 0x20010001; then halted=1 and out_valid=0.
REQ-024 Backpressure: out_ready=0 for 3 cycles while out_pc=2 -> out_instr holds 0x00011020; the next beat has out_pc=3.
REQ-025 Redirect in RUN: redirect_valid=1 to addr 5 while out_pc=10 is presented -> that beat is dropped; the next beat has out_pc=5.
REQ-026 Redirect from HALT to addr 12 -> one beat 0x0800000C with out_pc=12, then HALT again.
REQ-027 Wrap and reset: RESET_PC=0x3FFFFFFF, imem_end=0 -> out_pc 0x3FFFFFFF then 0; rst_n=0 mid-run -> out_valid=0 next cycle, IDLE.

Source files
------------

// File: rtl/mod_instruction_fetch_pkg.sv
// Shared fetch-unit package: FSM encoding and default geometry.
package mod_instruction_fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 30;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mod_fetch_slot.sv
// One-entry valid/ready output register with flush.
module mod_fetch_slot
    import mod_instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Flush beats load; an unloaded slot drains when accepted.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/mod_instruction_fetch.sv
// Instruction fetch: pc/FSM driving a combinational ROM into a one-entry slot.
module mod_instruction_fetch
    import mod_instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              imem_end,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush, load, slot_free;

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_addr;
                end else if (slot_free) begin
                    if (imem_end) begin
                        state_d = ST_HALT;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_addr;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    mod_fetch_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (load),
        .instr_i (imem_instr),
        .pc_i    (pc_q),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .instr_o (out_instr),
        .pc_o    (out_pc)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule
